// File: rtl/dsp_pkg.sv
// Shared definitions for the biquad filter datapath: default sample width and sample type.
package dsp_pkg;

   localparam int WIDTH = 32;

   typedef logic signed [WIDTH-1:0] sample_t;

endpackage

// File: rtl/bqf_mac4.sv
// Four-term signed multiply-accumulate for the biquad section.
// Products are full precision; the sum wraps to the low W bits.
module bqf_mac4 #(
   parameter int W = dsp_pkg::WIDTH
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   input  logic signed [W-1:0] c,
   input  logic signed [W-1:0] d,
   input  logic signed [W-1:0] x0,
   input  logic signed [W-1:0] x1,
   input  logic signed [W-1:0] y1,
   input  logic signed [W-1:0] y2,
   output logic signed [W-1:0] sum
);

   localparam int PW = 2 * W;
   localparam int SW = 2 * W + 2;

   logic signed [PW-1:0] p_a, p_b, p_c, p_d;
   logic signed [SW-1:0] acc;
   logic                 unused_acc_hi;

   // Operands are sign-extended to 2W first so the low 2W bits of each
   // product are the exact signed product.
   function automatic logic signed [PW-1:0] smul(input logic signed [W-1:0] u,
                                                 input logic signed [W-1:0] v);
      logic signed [PW-1:0] ue, ve;
      ue = {{W{u[W-1]}}, u};
      ve = {{W{v[W-1]}}, v};
      return ue * ve;
   endfunction

   function automatic logic signed [SW-1:0] sext(input logic signed [PW-1:0] p);
      return {{2{p[PW-1]}}, p};
   endfunction

   always_comb begin
      p_a = smul(a, x0);
      p_b = smul(b, x1);
      p_c = smul(c, y1);
      p_d = smul(d, y2);
      acc = (sext(p_a) + sext(p_b)) + (sext(p_c) + sext(p_d));
   end

   assign sum           = acc[W-1:0];
   assign unused_acc_hi = ^acc[SW-1:W];

endmodule

// File: rtl/dsp_bqf.sv
// Biquad IIR section: y[n] = A*x[n] + B*x[n-1] + C*y[n-1] + D*y[n-2], one sample per clock.
// Holds only the history registers; arithmetic lives in bqf_mac4.
module dsp_bqf #(
   parameter int WIDTH = dsp_pkg::WIDTH
) (
   input  logic signed [WIDTH-1:0] A,
   input  logic signed [WIDTH-1:0] B,
   input  logic signed [WIDTH-1:0] C,
   input  logic signed [WIDTH-1:0] D,
   input  logic signed [WIDTH-1:0] Xin,
   output logic signed [WIDTH-1:0] out,
   input  logic                    clk,
   input  logic                    clr
);

   logic signed [WIDTH-1:0] x1_q, x1_d;
   logic signed [WIDTH-1:0] y1_q, y1_d;
   logic signed [WIDTH-1:0] y2_q, y2_d;
   logic signed [WIDTH-1:0] mac_sum;

   bqf_mac4 #(.W(WIDTH)) u_mac (
      .a   (A),
      .b   (B),
      .c   (C),
      .d   (D),
      .x0  (Xin),
      .x1  (x1_q),
      .y1  (y1_q),
      .y2  (y2_q),
      .sum (mac_sum)
   );

   always_comb begin
      x1_d = Xin;
      y1_d = mac_sum;
      y2_d = y1_q;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         x1_q <= '0;
         y1_q <= '0;
         y2_q <= '0;
      end else begin
         x1_q <= x1_d;
         y1_q <= y1_d;
         y2_q <= y2_d;
      end
   end

   // y1 is the output register, so out clears asynchronously with it.
   assign out = y1_q;

endmodule

// File: tb/tb_dsp_bqf.sv
// Directed self-checking bench for dsp_bqf: step, impulse, signed feedback,
// wrap-around, async reset mid-run and reset held under clock.
module tb_dsp_bqf;

   import dsp_pkg::*;

   logic    clk;
   logic    clr;
   sample_t A, B, C, D, Xin;
   sample_t out;

   int checks;
   int failures;

   dsp_bqf dut (
      .A   (A),
      .B   (B),
      .C   (C),
      .D   (D),
      .Xin (Xin),
      .out (out),
      .clk (clk),
      .clr (clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input sample_t obs, input sample_t exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset between edges; the next edge is the first update.
   task automatic pulse_reset();
      clr = 1'b0;
      #1;
      clr = 1'b1;
   endtask

   task automatic set_coefs(input sample_t a_v, input sample_t b_v,
                            input sample_t c_v, input sample_t d_v);
      A = a_v;
      B = b_v;
      C = c_v;
      D = d_v;
   endtask

   initial begin
      sample_t step_exp [5];
      checks   = 0;
      failures = 0;
      step_exp = '{32'sd5, 32'sd30, 32'sd125, 32'sd510, 32'sd2045};

      clr = 1'b0;
      set_coefs(0, 0, 0, 0);
      Xin = 0;
      #3;
      check("reset_initial", out, 0);

      // Reset held while the clock runs and inputs wander.
      for (int i = 0; i < 10; i++) begin
         set_coefs($urandom, $urandom, $urandom, $urandom);
         Xin = $urandom;
         tick();
         check($sformatf("reset_held_%0d", i), out, 0);
      end

      // Step response.
      set_coefs(1, 2, 3, 4);
      Xin = 5;
      clr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("step_%0d", i), out, step_exp[i]);
      end

      // Asynchronous reset between edges, then restart from power-up.
      #2;
      clr = 1'b0;
      #1;
      check("async_reset_no_edge", out, 0);
      #1;
      clr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("step_restart_%0d", i), out, step_exp[i]);
      end

      // Feedforward-only impulse/hold.
      pulse_reset();
      set_coefs(1, 0, 0, 0);
      Xin = 7;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("ff_hold_%0d", i), out, 7);
      end

      // Signed feedback with C = -1.
      pulse_reset();
      set_coefs(1, 0, 32'hFFFF_FFFF, 0);
      Xin = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("fb_alt_%0d", i), out, (i % 2 == 0) ? 32'sd1 : 32'sd0);
      end

      // Modulo wrap.
      pulse_reset();
      set_coefs(2, 0, 0, 0);
      Xin = 32'h8000_0000;
      tick();
      check("wrap_neg_2p32", out, 0);
      Xin = 32'h4000_0000;
      tick();
      check("wrap_2p31", out, 32'h8000_0000);

      // Negative coefficient times positive sample.
      pulse_reset();
      set_coefs(-3, 0, 0, 0);
      Xin = 5;
      tick();
      check("neg_coef", out, 32'hFFFF_FFF1);

      // B term in isolation: output is x[n-1].
      pulse_reset();
      set_coefs(0, 1, 0, 0);
      Xin = 9;
      tick();
      check("b_only_first", out, 0);
      Xin = 4;
      tick();
      check("b_only_delay", out, 9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
